// File: rtl/pipe_seq_ctrl.sv
// pipe_seq_ctrl - sequencing controller for the 3-stage fetch/decode/execute pipe.
// Generates the PC increment enable and the stage advance, flush and bubble controls.
// It also tracks the stage-2/stage-3 valid bits and counts stall cycles.
// Optional memory watchdog: define PIPE_SEQ_CTRL_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | after reset, waiting for run
// FILL     | refilling the pipe for FILL_CYC cycles after start or flush
// RUN      | normal issue; resolves flush > memory > RAW bubble > halt
// MEM_WAIT | stage 3 holding until data memory acknowledges
// HALT     | stopped with valid bits kept; run resumes without refill
module pipe_seq_ctrl #(
    parameter int FILL_CYC = 2,
    parameter int CNT_W    = 8,
    parameter int MEM_TO   = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             run,
    input  logic             l_pc,
    input  logic             s2_rd_use,
    input  logic [2:0]       s2_rd_addr,
    input  logic             s3_we,
    input  logic [2:0]       s3_wr_addr,
    input  logic             s3_mem,
    input  logic             mem_ack,
    input  logic             stat_clr,
    output logic             i_pc,
    output logic             en_s1,
    output logic             en_s2,
    output logic             bubble_s2,
    output logic             flush_s1,
    output logic             flush_s2,
    output logic             mem_req,
    output logic             v2,
    output logic             v3,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             mem_err
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FILL     = 3'd1,
        ST_RUN      = 3'd2,
        ST_MEM_WAIT = 3'd3,
        ST_HALT     = 3'd4
    } state_t;

    localparam logic [1:0]       FILL_LOAD = 2'(FILL_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state_q, state_d;
    logic [1:0]       fill_cnt_q, fill_cnt_d;
    logic             v2_q, v3_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             raw_hit;
    logic             stall_inc;
    logic             to_hit;

    assign raw_hit = v2_q & v3_q & s2_rd_use & s3_we & (s2_rd_addr == s3_wr_addr);

`ifdef PIPE_SEQ_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(MEM_TO + 1);

    logic [TO_W-1:0] to_cnt_q;
    logic            mem_err_q;

    // to_hit fires on the MEM_TO-th consecutive MEM_WAIT cycle without an ack
    assign to_hit = (state_q == ST_MEM_WAIT) && !mem_ack && (to_cnt_q == TO_W'(1));

    // Watchdog down-counter, loaded on entry to MEM_WAIT; sticky error flag
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            to_cnt_q  <= '0;
            mem_err_q <= 1'b0;
        end else begin
            if (state_q == ST_RUN && state_d == ST_MEM_WAIT) begin
                to_cnt_q <= TO_W'(MEM_TO);
            end else if (state_q == ST_MEM_WAIT && to_cnt_q != '0) begin
                to_cnt_q <= to_cnt_q - 1'b1;
            end
            if (to_hit) begin
                mem_err_q <= 1'b1;
            end
        end
    end

    assign mem_err = mem_err_q;
`else
    // No watchdog: MEM_TO only keeps the parameter list identical across builds
    assign to_hit  = (MEM_TO < 0);
    assign mem_err = 1'b0;
`endif

    // State and fill-counter registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q    <= ST_IDLE;
            fill_cnt_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
        end
    end

    // Next-state and combinational pipeline controls
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        i_pc       = 1'b0;
        en_s1      = 1'b0;
        en_s2      = 1'b0;
        bubble_s2  = 1'b0;
        flush_s1   = 1'b0;
        flush_s2   = 1'b0;
        mem_req    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d    = ST_FILL;
                    fill_cnt_d = FILL_LOAD;
                end
            end
            ST_FILL: begin
                i_pc       = 1'b1;
                en_s1      = 1'b1;
                en_s2      = 1'b1;
                fill_cnt_d = fill_cnt_q - 1'b1;
                if (fill_cnt_q <= 2'd1) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (l_pc && v3_q) begin
                    // PC loads the target, so no increment this cycle
                    flush_s1   = 1'b1;
                    flush_s2   = 1'b1;
                    en_s1      = 1'b1;
                    en_s2      = 1'b1;
                    state_d    = ST_FILL;
                    fill_cnt_d = FILL_LOAD;
                end else if (s3_mem && v3_q) begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        i_pc  = 1'b1;
                        en_s1 = 1'b1;
                        en_s2 = 1'b1;
                    end else begin
                        state_d = ST_MEM_WAIT;
                    end
                end else if (raw_hit) begin
                    // NOP into stage 3; stage 2 holds its read until the write retires
                    bubble_s2 = 1'b1;
                    en_s2     = 1'b1;
                end else if (!run) begin
                    state_d = ST_HALT;
                end else begin
                    i_pc  = 1'b1;
                    en_s1 = 1'b1;
                    en_s2 = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                mem_req = 1'b1;
                if (to_hit) begin
                    state_d = ST_HALT;
                end else if (mem_ack) begin
                    i_pc    = 1'b1;
                    en_s1   = 1'b1;
                    en_s2   = 1'b1;
                    state_d = run ? ST_RUN : ST_HALT;
                end
            end
            ST_HALT: begin
                if (run) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Stage valid bits follow the advance enables; a watchdog abort drops stage 3
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else begin
            if (en_s1) begin
                v2_q <= ~flush_s1;
            end
            if (to_hit) begin
                v3_q <= 1'b0;
            end else if (en_s2) begin
                v3_q <= v2_q & ~bubble_s2 & ~flush_s2;
            end
        end
    end

    // A stall is any RUN/MEM_WAIT cycle without PC increment, except a flush
    assign stall_inc = ((state_q == ST_RUN) || (state_q == ST_MEM_WAIT)) && !i_pc && !flush_s1;

    // Saturating stall counter; clear wins over increment
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            stall_cnt_q <= '0;
        end else if (stat_clr) begin
            stall_cnt_q <= '0;
        end else if (stall_inc && stall_cnt_q != CNT_MAX) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign state     = state_q;
    assign v2        = v2_q;
    assign v3        = v3_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// tb_pipe_seq_ctrl - directed and randomized bench for pipe_seq_ctrl.
// Honours PIPE_SEQ_CTRL_TIMEOUT_EN when the design is built with it.
module tb_pipe_seq_ctrl;

    localparam int FILL_CYC  = 2;
    localparam int CNT_W     = 4;
    localparam int MEM_TO    = 16;
    localparam int STALL_MAX = (1 << CNT_W) - 1;

    localparam int S_IDLE = 0, S_FILL = 1, S_RUN = 2, S_MW = 3, S_HALT = 4;

    logic             clk;
    logic             clr_n;
    logic             run, l_pc, s2_rd_use, s3_we, s3_mem, mem_ack, stat_clr;
    logic [2:0]       s2_rd_addr, s3_wr_addr;
    logic             i_pc, en_s1, en_s2, bubble_s2, flush_s1, flush_s2, mem_req;
    logic             v2, v3, mem_err;
    logic [2:0]       state;
    logic [CNT_W-1:0] stall_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model: spec-level pipeline status
    int m_st, m_nst, m_fill_done, m_mw, m_stall;
    bit m_v2, m_v3, m_err, m_stall_evt, m_to_fire;
    bit e_ipc, e_en1, e_en2, e_bub, e_fl, e_req;

    int n_req, n_low;
    bit r_run, r_lp, r_use, r_we, r_mem, r_ack, r_sc;
    logic [2:0] r_ra, r_wa;

    pipe_seq_ctrl #(.FILL_CYC(FILL_CYC), .CNT_W(CNT_W), .MEM_TO(MEM_TO)) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .run        (run),
        .l_pc       (l_pc),
        .s2_rd_use  (s2_rd_use),
        .s2_rd_addr (s2_rd_addr),
        .s3_we      (s3_we),
        .s3_wr_addr (s3_wr_addr),
        .s3_mem     (s3_mem),
        .mem_ack    (mem_ack),
        .stat_clr   (stat_clr),
        .i_pc       (i_pc),
        .en_s1      (en_s1),
        .en_s2      (en_s2),
        .bubble_s2  (bubble_s2),
        .flush_s1   (flush_s1),
        .flush_s2   (flush_s2),
        .mem_req    (mem_req),
        .v2         (v2),
        .v3         (v3),
        .state      (state),
        .stall_cnt  (stall_cnt),
        .mem_err    (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = S_IDLE; m_nst = S_IDLE; m_fill_done = 0; m_mw = 0; m_stall = 0;
        m_v2 = 0; m_v3 = 0; m_err = 0; m_stall_evt = 0; m_to_fire = 0;
    endtask

    // What the outputs must be this cycle, and where the pipe goes next
    task automatic model_outputs();
        bit hazard;
        hazard = m_v2 && m_v3 && s2_rd_use && s3_we && (s2_rd_addr == s3_wr_addr);
        e_ipc = 0; e_en1 = 0; e_en2 = 0; e_bub = 0; e_fl = 0; e_req = 0;
        m_to_fire = 0;
        m_nst = m_st;
        case (m_st)
            S_IDLE: if (run) m_nst = S_FILL;
            S_FILL: begin
                e_ipc = 1; e_en1 = 1; e_en2 = 1;
                if (m_fill_done + 1 == FILL_CYC) m_nst = S_RUN;
            end
            S_RUN: begin
                if (l_pc && m_v3) begin
                    e_fl = 1; e_en1 = 1; e_en2 = 1; m_nst = S_FILL;
                end else if (s3_mem && m_v3) begin
                    e_req = 1;
                    if (mem_ack) begin e_ipc = 1; e_en1 = 1; e_en2 = 1; end
                    else m_nst = S_MW;
                end else if (hazard) begin
                    e_bub = 1; e_en2 = 1;
                end else if (!run) begin
                    m_nst = S_HALT;
                end else begin
                    e_ipc = 1; e_en1 = 1; e_en2 = 1;
                end
            end
            S_MW: begin
                e_req = 1;
`ifdef PIPE_SEQ_CTRL_TIMEOUT_EN
                if (!mem_ack && (m_mw + 1 == MEM_TO)) begin
                    m_to_fire = 1; m_nst = S_HALT;
                end else
`endif
                if (mem_ack) begin
                    e_ipc = 1; e_en1 = 1; e_en2 = 1;
                    m_nst = run ? S_RUN : S_HALT;
                end
            end
            S_HALT: if (run) m_nst = S_RUN;
            default: m_nst = S_IDLE;
        endcase
        m_stall_evt = (m_st == S_RUN || m_st == S_MW) && !e_ipc && !e_fl;
    endtask

    task automatic model_advance();
        bit nv2, nv3;
        nv2 = e_en1 ? !e_fl : m_v2;
        if (m_to_fire) nv3 = 0;
        else if (e_en2) nv3 = m_v2 && !e_bub && !e_fl;
        else nv3 = m_v3;
        if (stat_clr) m_stall = 0;
        else if (m_stall_evt && m_stall < STALL_MAX) m_stall++;
        if (m_to_fire) m_err = 1;
        if (m_nst == S_FILL && m_st != S_FILL) m_fill_done = 0;
        else if (m_st == S_FILL) m_fill_done++;
        if (m_nst == S_MW && m_st != S_MW) m_mw = 0;
        else if (m_st == S_MW) m_mw++;
        m_v2 = nv2; m_v3 = nv3; m_st = m_nst;
    endtask

    task automatic compare_all();
        chk("i_pc", i_pc, e_ipc);
        chk("en_s1", en_s1, e_en1);
        chk("en_s2", en_s2, e_en2);
        chk("bubble_s2", bubble_s2, e_bub);
        chk("flush_s1", flush_s1, e_fl);
        chk("flush_s2", flush_s2, e_fl);
        chk("mem_req", mem_req, e_req);
        chk("v2", v2, m_v2);
        chk("v3", v3, m_v3);
        chk("state", state, m_st);
        chk("stall_cnt", stall_cnt, m_stall);
        chk("mem_err", mem_err, m_err);
    endtask

    // Apply inputs after the falling edge and check the model mid-cycle
    task automatic drive(input bit r, input bit lp, input bit u, input logic [2:0] ra,
                         input bit w, input logic [2:0] wa, input bit m, input bit a,
                         input bit sc);
        @(negedge clk);
        run = r; l_pc = lp; s2_rd_use = u; s2_rd_addr = ra;
        s3_we = w; s3_wr_addr = wa; s3_mem = m; mem_ack = a; stat_clr = sc;
        #1;
        model_outputs();
        compare_all();
    endtask

    task automatic tick();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic adv();
        drive(1, 0, 0, 3'd0, 0, 3'd1, 0, 0, 0);
        tick();
    endtask

    task automatic hard_reset();
        @(negedge clk);
        run = 0; l_pc = 0; s2_rd_use = 0; s2_rd_addr = 0; s3_we = 0; s3_wr_addr = 0;
        s3_mem = 0; mem_ack = 0; stat_clr = 0;
        clr_n = 0;
        model_reset();
        @(negedge clk);
        clr_n = 1;
    endtask

    initial begin
        clr_n = 0;
        run = 0; l_pc = 0; s2_rd_use = 0; s2_rd_addr = 0; s3_we = 0; s3_wr_addr = 0;
        s3_mem = 0; mem_ack = 0; stat_clr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", state, 0);
        chk("rst_v2", v2, 0);
        chk("rst_v3", v3, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_mem_req", mem_req, 0);
        @(negedge clk);
        clr_n = 1;

        // start: one IDLE cycle, then FILL_CYC fill cycles
        drive(1, 0, 0, 3'd0, 0, 3'd1, 0, 0, 0);
        chk("idle_ipc", i_pc, 0);
        tick();
        drive(1, 0, 0, 3'd0, 0, 3'd1, 0, 0, 0);
        chk("fill_ipc", i_pc, 1);
        chk("fill_state", state, 1);
        tick();
        adv();
        chk("run_state", state, 2);
        chk("run_v2", v2, 1);
        chk("run_v3", v3, 1);
        chk("run_stall", stall_cnt, 0);

        // taken PC load flushes and refills
        drive(1, 1, 0, 3'd0, 0, 3'd1, 0, 0, 0);
        chk("flush_s1_lit", flush_s1, 1);
        chk("flush_s2_lit", flush_s2, 1);
        chk("flush_ipc", i_pc, 0);
        tick();
        chk("flush_next_state", state, 1);
        chk("flush_next_v2", v2, 0);
        chk("flush_next_v3", v3, 0);
        adv();
        adv();
        chk("refill_state", state, 2);

        // RAW hazard on r5
        drive(1, 0, 1, 3'd5, 1, 3'd5, 0, 0, 0);
        chk("raw_bubble", bubble_s2, 1);
        chk("raw_en_s1", en_s1, 0);
        chk("raw_ipc", i_pc, 0);
        tick();
        drive(1, 0, 1, 3'd5, 1, 3'd5, 0, 0, 0);
        chk("raw_after_v3", v3, 0);
        chk("raw_after_ipc", i_pc, 1);
        chk("raw_after_stall", stall_cnt, 1);
        tick();

        // memory access acknowledged on the fourth request cycle
        n_req = 0; n_low = 0;
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 0, 3'd0, 0, 3'd1, 1, (k == 3), 0);
            if (mem_req) n_req++;
            if (!i_pc) n_low++;
            if (k == 1) chk("mem_wait_state", state, 3);
            tick();
        end
        chk("mem_req_cycles", n_req, 4);
        chk("mem_stall_cycles", n_low, 3);
        chk("mem_done_state", state, 2);
        chk("mem_stall_cnt", stall_cnt, 4);

        // same-cycle ack: no stall
        drive(1, 0, 0, 3'd0, 0, 3'd1, 1, 1, 0);
        chk("fast_mem_req", mem_req, 1);
        chk("fast_mem_ipc", i_pc, 1);
        tick();
        chk("fast_mem_state", state, 2);
        chk("fast_mem_stall", stall_cnt, 4);

        // flush beats memory and RAW
        drive(1, 1, 1, 3'd5, 1, 3'd5, 1, 0, 0);
        chk("prio_flush", flush_s1, 1);
        chk("prio_mem_req", mem_req, 0);
        chk("prio_bubble", bubble_s2, 0);
        tick();
        chk("prio_state", state, 1);
        adv();
        adv();

        // long wait saturates the stall counter; stat_clr beats a stall
        for (int k = 0; k < 15; k++) begin
            drive(1, 0, 0, 3'd0, 0, 3'd1, 1, 0, 0);
            tick();
        end
        chk("sat_stall", stall_cnt, STALL_MAX);
        chk("sat_state", state, 3);
        drive(1, 0, 0, 3'd0, 0, 3'd1, 0, 0, 1);
        tick();
        chk("clr_stall", stall_cnt, 0);
        drive(1, 0, 0, 3'd0, 0, 3'd1, 0, 1, 0);
        tick();
        chk("sat_exit_state", state, 2);

        // deferred halt: run drops while waiting, takes effect on the ack
        drive(1, 0, 0, 3'd0, 0, 3'd1, 1, 0, 0);
        tick();
        drive(0, 0, 0, 3'd0, 0, 3'd1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 3'd0, 0, 3'd1, 0, 1, 0);
        chk("defer_ack_ipc", i_pc, 1);
        tick();
        chk("defer_halt_state", state, 4);
        adv();
        chk("halt_resume_state", state, 2);

        // asynchronous reset in the middle of MEM_WAIT
        drive(1, 0, 0, 3'd0, 0, 3'd1, 1, 0, 0);
        tick();
        drive(1, 0, 0, 3'd0, 0, 3'd1, 0, 0, 0);
        chk("pre_rst_mem_req", mem_req, 1);
        #2;
        run = 0;
        clr_n = 0;
        #1;
        chk("async_mem_req", mem_req, 0);
        chk("async_state", state, 0);
        model_reset();
        @(negedge clk);
        clr_n = 1;

`ifdef PIPE_SEQ_CTRL_TIMEOUT_EN
        adv();
        adv();
        adv();
        for (int k = 0; k < MEM_TO + 1; k++) begin
            drive(1, 0, 0, 3'd0, 0, 3'd1, 1, 0, 0);
            tick();
        end
        chk("to_mem_err", mem_err, 1);
        chk("to_state", state, 4);
        chk("to_mem_req", mem_req, 0);
        chk("to_v3", v3, 0);
        hard_reset();
        #1;
        chk("to_err_cleared", mem_err, 0);
`endif

        // randomized traffic
        hard_reset();
        for (int i = 0; i < 3000; i++) begin
            r_run = ($urandom_range(0, 15) != 0);
            r_lp  = ($urandom_range(0, 7) == 0);
            r_use = 1'($urandom_range(0, 1));
            r_ra  = 3'($urandom_range(0, 3));
            r_we  = 1'($urandom_range(0, 1));
            r_wa  = 3'($urandom_range(0, 3));
            r_mem = ($urandom_range(0, 3) == 0);
            r_ack = ($urandom_range(0, 2) == 0);
            r_sc  = ($urandom_range(0, 63) == 0);
            drive(r_run, r_lp, r_use, r_ra, r_we, r_wa, r_mem, r_ack, r_sc);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
